multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Sequences fetch/decode/execute/memory/writeback and drives the immediate generator's select (imm_sel).
- Drives the PC, IR, register-file and memory strobes.
- Sits between the instruction register, the memory ports and the datapath muxes. Adds a memory-wait watchdog and a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath selects and strobes, and adds a memory-wait watchdog and instret counter.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [2:0]       imm_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPI, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST
  } cls_t;

  state_t              state_q, state_d;
  cls_t                cls_q, cls_d, dec_cls;
  logic [2:0]          imm_sel_q, imm_sel_d, dec_imm;
  logic                alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic [CNT_W-1:0]    instret_q, instret_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                dec_ok, rdy, waiting, wd_fire;
  logic                unused_instr;

  assign unused_instr = ^instr[31:7];

  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_OP;
    dec_imm = 3'b000;
    case (instr[6:0])
      7'b0110111: begin dec_cls = C_LUI;   dec_imm = 3'b011; end
      7'b0010111: begin dec_cls = C_AUIPC; dec_imm = 3'b011; end
      7'b1101111: begin dec_cls = C_JAL;   dec_imm = 3'b100; end
      7'b1100111: begin dec_cls = C_JALR;  dec_imm = 3'b000; end
      7'b1100011: begin dec_cls = C_BR;    dec_imm = 3'b010; end
      7'b0000011: begin dec_cls = C_LD;    dec_imm = 3'b000; end
      7'b0100011: begin dec_cls = C_ST;    dec_imm = 3'b001; end
      7'b0010011: begin dec_cls = C_OPI;   dec_imm = 3'b000; end
      7'b0110011: begin dec_cls = C_OP;    dec_imm = 3'b000; end
      default:    dec_ok = 1'b0;
    endcase
  end

  // The watchdog only watches the ready line that belongs to the current request.
  assign rdy     = (state_q == FETCH) ? imem_ready : dmem_ready;
  assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !rdy;
  assign wd_fire = (TIMEOUT != 0) && waiting && (32'(wait_q) == TIMEOUT - 1);

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    imm_sel_d = imm_sel_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    instret_d = instret_q;
    case (state_q)
      FETCH: begin
        if (imem_ready)   state_d = DECODE;
        else if (wd_fire) begin state_d = TRAP; bus_err_d = 1'b1; end
      end
      DECODE: begin
        if (dec_ok) begin
          state_d   = EXEC;
          cls_d     = dec_cls;
          imm_sel_d = dec_imm;
          alu_a_d   = (dec_cls == C_AUIPC) || (dec_cls == C_JAL) || (dec_cls == C_BR);
          alu_b_d   = (dec_cls != C_OP);
        end else begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        if (cls_q == C_BR) begin
          state_d   = FETCH;
          instret_d = instret_q + CNT_W'(1);
        end else if ((cls_q == C_LD) || (cls_q == C_ST)) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (dmem_ready) begin
          if (cls_q == C_ST) begin
            state_d   = FETCH;
            instret_d = instret_q + CNT_W'(1);
          end else begin
            state_d = WB;
          end
        end else if (wd_fire) begin
          state_d   = TRAP;
          bus_err_d = 1'b1;
        end
      end
      WB: begin
        state_d   = FETCH;
        instret_d = instret_q + CNT_W'(1);
      end
      default: state_d = TRAP;
    endcase
    wait_d = (waiting && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;
  end

  // Requests and strobes are gated by rst_n so an asserted reset kills them at once.
  always_comb begin
    imem_req = rst_n && (state_q == FETCH);
    ir_we    = rst_n && (state_q == FETCH) && imem_ready;
    dmem_req = rst_n && (state_q == MEM);
    dmem_we  = rst_n && (state_q == MEM) && (cls_q == C_ST);
    reg_we   = rst_n && (state_q == WB);
    pc_we    = rst_n && (((state_q == EXEC) && (cls_q == C_BR)) ||
                         ((state_q == MEM) && (cls_q == C_ST) && dmem_ready) ||
                         (state_q == WB));
    pc_sel   = 2'b00;
    wb_sel   = 2'b00;
    if ((state_q == EXEC) && (cls_q == C_BR)) pc_sel = {1'b0, br_taken};
    if (state_q == WB) begin
      if (cls_q == C_JAL)       pc_sel = 2'b01;
      else if (cls_q == C_JALR) pc_sel = 2'b10;
      if (cls_q == C_LD)                             wb_sel = 2'b01;
      else if ((cls_q == C_JAL) || (cls_q == C_JALR)) wb_sel = 2'b10;
    end
  end

  assign alu_a_sel = alu_a_q;
  assign alu_b_sel = alu_b_q;
  assign imm_sel   = imm_sel_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign instret   = instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      cls_q     <= C_OP;
      imm_sel_q <= 3'b000;
      alu_a_q   <= 1'b0;
      alu_b_q   <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      imm_sel_q <= imm_sel_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from the
// instruction-level rules, random waits and instructions, plus trap/reset scenarios.
module tb_multicycle_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instr = 32'h0;
  logic          br_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic [1:0]    pc_sel, wb_sel;
  logic          alu_a_sel, alu_b_sel, illegal, bus_err;
  logic [2:0]    imm_sel;
  logic [CW-1:0] instret;
  logic [16:0]   got;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .imm_sel(imm_sel),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  assign got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                alu_a_sel, alu_b_sel, imm_sel, illegal, bus_err};

  typedef struct {
    logic        ir, dr, bt;
    logic [16:0] exp, msk;
    logic [CW-1:0] cnt;
  } step_t;

  step_t       q[$];
  logic [2:0]  h_imm;
  logic        h_a, h_b, h_ill, h_bus;
  int          cnt;
  int          n_chk = 0, n_pass = 0;

  localparam int K_OP = 0, K_OPI = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4,
                 K_JALR = 5, K_BR = 6, K_LD = 7, K_ST = 8, K_BAD = 9;

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
    n_chk++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, g, e, $time);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic model_reset();
    h_imm = 3'b000; h_a = 1'b0; h_b = 1'b0; h_ill = 1'b0; h_bus = 1'b0;
    cnt = 0;
    q.delete();
  endtask

  task automatic push(input logic ir, input logic dr, input logic bt,
                      input logic imr, input logic dmr, input logic dwe,
                      input logic irw, input logic pcw, input logic [1:0] pcs,
                      input logic rw, input logic [1:0] wbs, input logic retire);
    step_t s;
    s.ir = ir; s.dr = dr; s.bt = bt;
    s.exp = {imr, dmr, dwe, irw, pcw, pcs, rw, wbs, h_a, h_b, h_imm, h_ill, h_bus};
    s.msk = 17'h1FFFF;
    s.cnt = CW'(cnt);
    q.push_back(s);
    if (retire) cnt = (cnt + 1) % (1 << CW);
  endtask

  task automatic add_trap(input int n);
    for (int i = 0; i < n; i++) begin
      push(rb(), rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
      q[q.size()-1].msk = 17'h1FF83;
    end
  endtask

  task automatic ref_decode(input logic [6:0] op, output int k, output logic [2:0] im,
                            output logic a, output logic b);
    case (op)
      7'b0110111: begin k = K_LUI;   im = 3'b011; a = 0; b = 1; end
      7'b0010111: begin k = K_AUIPC; im = 3'b011; a = 1; b = 1; end
      7'b1101111: begin k = K_JAL;   im = 3'b100; a = 1; b = 1; end
      7'b1100111: begin k = K_JALR;  im = 3'b000; a = 0; b = 1; end
      7'b1100011: begin k = K_BR;    im = 3'b010; a = 1; b = 1; end
      7'b0000011: begin k = K_LD;    im = 3'b000; a = 0; b = 1; end
      7'b0100011: begin k = K_ST;    im = 3'b001; a = 0; b = 1; end
      7'b0010011: begin k = K_OPI;   im = 3'b000; a = 0; b = 1; end
      7'b0110011: begin k = K_OP;    im = 3'b000; a = 0; b = 0; end
      default:    begin k = K_BAD;   im = 3'b000; a = 0; b = 0; end
    endcase
  endtask

  // Expected cycle-by-cycle trace of one instruction; instr itself is driven by run_q.
  task automatic add_instr(input int fw, input int dw, input logic bt, input logic [6:0] op);
    int k; logic [2:0] im; logic a, b, st;
    logic [1:0] wbs, pcs;
    ref_decode(op, k, im, a, b);
    for (int i = 0; i < fw; i++) push(0, rb(), rb(), 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    push(1, rb(), rb(), 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0);
    push(rb(), rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    if (k == K_BAD) begin h_ill = 1'b1; return; end
    h_imm = im; h_a = a; h_b = b;
    if (k == K_BR) begin
      push(rb(), rb(), bt, 0, 0, 0, 0, 1, {1'b0, bt}, 0, 2'b00, 1);
      return;
    end
    push(rb(), rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    if (k == K_LD || k == K_ST) begin
      st = (k == K_ST);
      for (int i = 0; i < dw; i++) push(rb(), 0, rb(), 0, 1, st, 0, 0, 2'b00, 0, 2'b00, 0);
      push(rb(), 1, rb(), 0, 1, st, 0, st, 2'b00, 0, 2'b00, st);
      if (st) return;
    end
    wbs = (k == K_LD) ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00;
    pcs = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
    push(rb(), rb(), rb(), 0, 0, 0, 0, 1, pcs, 1, wbs, 1);
  endtask

  // Called at a falling edge; leaves at a falling edge.
  task automatic run_q(input logic [31:0] ins);
    step_t s;
    instr = ins;
    while (q.size() > 0) begin
      s = q.pop_front();
      imem_ready = s.ir; dmem_ready = s.dr; br_taken = s.bt;
      #1;
      chk("outs", 32'(got & s.msk), 32'(s.exp & s.msk));
      chk("instret", 32'(instret), 32'(s.cnt));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outs", 32'(got), 32'h0);
    chk("rst_instret", 32'(instret), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                          7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

  initial begin
    logic [31:0] ins;
    model_reset();
    @(negedge clk);
    do_reset();

    add_instr(0, 0, 0, 7'h13); run_q(32'h00500093);
    add_instr(0, 0, 1, 7'h63); run_q(32'h00208463);
    add_instr(0, 0, 0, 7'h63); run_q(32'h00208463);
    add_instr(0, 2, 0, 7'h03); run_q(32'h0000A103);
    add_instr(3, 3, 0, 7'h23); run_q(32'h0020A023);

    // Illegal opcode: trap is sticky until reset.
    add_instr(0, 0, 0, 7'h0B); add_trap(6); run_q(32'h0000000B);
    do_reset();

    // Fetch watchdog: TO wait cycles with no ready.
    for (int i = 0; i < TO; i++) push(0, rb(), rb(), 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    h_bus = 1'b1; add_trap(5); run_q(32'h00500093);
    do_reset();

    // Asynchronous reset in the middle of a store's memory wait.
    add_instr(0, 0, 0, 7'h13); run_q(32'h00500093);
    add_instr(0, 2, 0, 7'h23);
    void'(q.pop_back()); void'(q.pop_back());
    run_q(32'h0020A023);
    dmem_ready = 1'b1;
    #1;
    chk("mem_req_pre", 32'(dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mem_abort_outs", 32'(got), 32'h0);
    @(posedge clk); #1;
    chk("abort_instret", 32'(instret), 32'h0);
    chk("abort_pc_we", 32'(pc_we), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    add_instr(1, 0, 0, 7'h13); run_q(32'h00500093);

    // Random instruction mix with 0..TO-1 wait cycles; instret wraps at 2^CW.
    for (int n = 0; n < 60; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 8)];
      add_instr($urandom_range(0, TO - 1), $urandom_range(0, TO - 1), rb(), ins[6:0]);
      run_q(ins);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
